// File: rtl/step_counter.sv
// -----------------------------------------------------------------------------
// step_counter
//
// Prescaled up-counter with a two-state run/idle controller. While running,
// a prescaler generates one tick every step_div+1 cycles; each tick either
// increments the count (sel=1) or clears it (sel=0). A synchronous load,
// a terminal-count indication and a sticky overflow flag are provided.
//
// Build option:
//   STEP_COUNTER_SAT_EN  undefined -> wrap mode: increment at MAX_VAL wraps
//                                     to 0, tc is a 1-cycle pulse after wrap.
//                        defined   -> saturate mode: increment at MAX_VAL
//                                     holds, tc is a level (count==MAX_VAL).
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous reset, active-low
//   start     in   1      request IDLE -> RUN
//   stop      in   1      request RUN -> IDLE (wins over start)
//   sel       in   1      tick action: 1 = increment, 0 = clear
//   step_div  in   DIV_W  one tick every step_div+1 RUN cycles
//   load      in   1      synchronous load of load_val (clamped to MAX_VAL)
//   load_val  in   WIDTH  value to load
//   ovf_clr   in   1      clears the sticky overflow flag
//   count     out  WIDTH  current count
//   running   out  1      1 while in RUN
//   tc        out  1      terminal-count indication
//   overflow  out  1      sticky overflow flag
// -----------------------------------------------------------------------------
module step_counter #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = (1 << WIDTH) - 1,
    parameter int DIV_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             sel,
    input  logic [DIV_W-1:0] step_div,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             tc,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             running_q, running_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic             tick;
    logic             ovf_set;
`ifndef STEP_COUNTER_SAT_EN
    logic             wrap;
`endif

    // Compare happens against the live step_div, so a new divisor takes
    // effect at the next compare.
    assign tick = (state_q == RUN) && (presc_q == step_div);

    // Priority: load > stop > tick. Anything lower is discarded on that edge.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, otherwise
        // paths that skip an assignment would infer a latch.
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        ovf_set = 1'b0;
`ifndef STEP_COUNTER_SAT_EN
        wrap    = 1'b0;
`endif

        if (load) begin
            // State is untouched by load; a coincident stop or start is lost.
            count_d = (load_val > MAX_C) ? MAX_C : load_val;
            presc_d = '0;
        end else if (stop) begin
            state_d = IDLE;
            presc_d = '0;
        end else if (state_q == IDLE) begin
            presc_d = '0;
            if (start) begin
                state_d = RUN;
            end
        end else if (tick) begin
            presc_d = '0;
            if (!sel) begin
                count_d = '0;
            end else if (count_q == MAX_C) begin
                ovf_set = 1'b1;
`ifdef STEP_COUNTER_SAT_EN
                count_d = MAX_C;
`else
                count_d = '0;
                wrap    = 1'b1;
`endif
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else begin
            presc_d = presc_q + DIV_W'(1);
        end

        // Set wins over a coincident clear.
        ovf_d     = ovf_set | (ovf_q & ~ovf_clr);
        running_d = (state_d == RUN);
`ifdef STEP_COUNTER_SAT_EN
        // Level derived from the next count so it lines up with count.
        tc_d      = (count_d == MAX_C);
`else
        // Pulse visible in the cycle after the wrap edge.
        tc_d      = wrap;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
            tc_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values regardless of order.
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            running_q <= running_d;
            tc_q      <= tc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign count    = count_q;
    assign running  = running_q;
    assign tc       = tc_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_step_counter.sv
// -----------------------------------------------------------------------------
// tb_step_counter
//
// Directed bench for step_counter. A default instance (WIDTH=4, MAX_VAL=15)
// carries most vectors; a second instance (WIDTH=5, MAX_VAL=12) shares the
// control inputs and covers load clamping and terminal behaviour at a
// non-power-of-two limit. Expected values follow the build option
// STEP_COUNTER_SAT_EN.
// -----------------------------------------------------------------------------
module tb_step_counter;

`ifdef STEP_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       sel;
    logic [7:0] step_div;
    logic       load;
    logic [3:0] load_val;
    logic [4:0] load_val5;
    logic       ovf_clr;

    logic [3:0] count;
    logic       running;
    logic       tc;
    logic       overflow;

    logic [4:0] count12;
    logic       running12;
    logic       tc12;
    logic       overflow12;

    int vectors;
    int miscompares;

    step_counter #(.WIDTH(4), .MAX_VAL(15), .DIV_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .sel      (sel),
        .step_div (step_div),
        .load     (load),
        .load_val (load_val),
        .ovf_clr  (ovf_clr),
        .count    (count),
        .running  (running),
        .tc       (tc),
        .overflow (overflow)
    );

    step_counter #(.WIDTH(5), .MAX_VAL(12), .DIV_W(8)) dut12 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .sel      (sel),
        .step_div (step_div),
        .load     (load),
        .load_val (load_val5),
        .ovf_clr  (ovf_clr),
        .count    (count12),
        .running  (running12),
        .tc       (tc12),
        .overflow (overflow12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("%s miscompare", tag);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        sel       = 1'b0;
        step_div  = 8'd0;
        load      = 1'b0;
        load_val  = 4'd0;
        load_val5 = 5'd0;
        ovf_clr   = 1'b0;

        // ---- reset ---------------------------------------------------------
        steps(3);
        check("rst_count",    32'(count),    32'd0);
        check("rst_running",  32'(running),  32'd0);
        check("rst_tc",       32'(tc),       32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // ---- 1: run from reset, step_div=0 ---------------------------------
        sel   = 1'b1;
        start = 1'b1;
        step();
        check("t1_running_rise", 32'(running), 32'd1);
        check("t1_count_at_start", 32'(count), 32'd0);
        start = 1'b0;
        steps(5);
        check("t1_count",    32'(count),    32'd5);
        check("t1_running",  32'(running),  32'd1);
        check("t1_tc",       32'(tc),       32'd0);
        check("t1_overflow", 32'(overflow), 32'd0);

        // stop holds count, tick on the stop edge is suppressed
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t1_stop_running", 32'(running), 32'd0);
        check("t1_stop_count",   32'(count),   32'd5);
        step();
        check("t1_idle_hold", 32'(count), 32'd5);

        // ---- 2: prescale step_div=3 -----------------------------------------
        load     = 1'b1;
        load_val = 4'd0;
        step();
        load = 1'b0;
        check("t2_load0", 32'(count), 32'd0);
        step_div = 8'd3;
        start    = 1'b1;
        step();
        start = 1'b0;
        steps(3);
        check("t2_before_first_tick", 32'(count), 32'd0);
        step();
        check("t2_first_tick", 32'(count), 32'd1);
        steps(8);
        check("t2_count12", 32'(count), 32'd3);
        sel = 1'b0;
        steps(3);
        check("t2_clear_wait", 32'(count), 32'd3);
        step();
        check("t2_clear", 32'(count), 32'd0);

        // ---- 3/4: wrap or saturate at MAX_VAL -------------------------------
        sel      = 1'b1;
        step_div = 8'd0;
        load     = 1'b1;
        load_val = 4'd14;
        step();
        load = 1'b0;
        check("t3_load14",   32'(count),   32'd14);
        check("t3_load_run", 32'(running), 32'd1);
        step();
        check("t3_c15",   32'(count),    32'd15);
        check("t3_tc15",  32'(tc),       SAT ? 32'd1 : 32'd0);
        check("t3_ovf15", 32'(overflow), 32'd0);
        step();
        check("t3_c_top",   32'(count),    SAT ? 32'd15 : 32'd0);
        check("t3_tc_top",  32'(tc),       32'd1);
        check("t3_ovf_top", 32'(overflow), 32'd1);
        step();
        check("t3_c_next",   32'(count),    SAT ? 32'd15 : 32'd1);
        check("t3_tc_next",  32'(tc),       SAT ? 32'd1 : 32'd0);
        check("t3_ovf_next", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        step();
        check("t3_c_clr",   32'(count),    SAT ? 32'd15 : 32'd2);
        check("t3_ovf_clr", 32'(overflow), SAT ? 32'd1 : 32'd0);
        stop = 1'b1;
        step();
        stop    = 1'b0;
        ovf_clr = 1'b0;
        check("t3_stopclr_ovf",     32'(overflow), 32'd0);
        check("t3_stopclr_running", 32'(running),  32'd0);
        check("t3_stopclr_count",   32'(count),    SAT ? 32'd15 : 32'd2);

        // set wins over a coincident ovf_clr
        load     = 1'b1;
        load_val = 4'd15;
        step();
        load = 1'b0;
        check("sw_load15_idle", 32'(count),   32'd15);
        check("sw_idle",        32'(running), 32'd0);
        start = 1'b1;
        step();
        start   = 1'b0;
        ovf_clr = 1'b1;
        check("sw_start_nohit", 32'(count), 32'd15);
        step();
        ovf_clr = 1'b0;
        check("sw_count", 32'(count),    SAT ? 32'd15 : 32'd0);
        check("sw_ovf",   32'(overflow), 32'd1);
        check("sw_tc",    32'(tc),       32'd1);

        // ---- 5: priority load > stop > tick ---------------------------------
        load     = 1'b1;
        load_val = 4'd7;
        stop     = 1'b1;
        step();
        load = 1'b0;
        check("t5_load_count",   32'(count),   32'd7);
        check("t5_load_running", 32'(running), 32'd1);
        step();
        stop = 1'b0;
        check("t5_stop_running", 32'(running), 32'd0);
        check("t5_stop_count",   32'(count),   32'd7);
        check("t5_ovf_kept",     32'(overflow), 32'd1);

        // clamp on a MAX_VAL=12 instance, then one increment at its limit
        load      = 1'b1;
        load_val5 = 5'd20;
        step();
        load = 1'b0;
        check("t5_clamp12", 32'(count12), 32'd12);
        check("t5_main_reload", 32'(count), 32'd7);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t5_main_inc",  32'(count),      32'd8);
        check("t5_c12_top",   32'(count12),    SAT ? 32'd12 : 32'd0);
        check("t5_tc12_top",  32'(tc12),       32'd1);
        check("t5_ovf12_top", 32'(overflow12), 32'd1);

        // start and stop together from IDLE: stop wins
        stop = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_idle", 32'(running), 32'd0);

        // ---- 6: asynchronous reset mid-run ----------------------------------
        start = 1'b1;
        step();
        start    = 1'b0;
        load     = 1'b1;
        load_val = 4'd9;
        step();
        load = 1'b0;
        check("t6_pre_count",   32'(count),    32'd9);
        check("t6_pre_running", 32'(running),  32'd1);
        check("t6_pre_ovf",     32'(overflow), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_count",    32'(count),    32'd0);
        check("t6_running",  32'(running),  32'd0);
        check("t6_tc",       32'(tc),       32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
        step();
        check("t6_hold_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
